dcache_mem_sched: RTL and testbench
===================================

// Module: dcache_mem_sched
// PURPOSE
// Schedules dcache misses and dirty-line writebacks onto one shared burst memory port, and returns refills.
// - Sits between the dcache miss/refill/writeback interfaces and the L2/bus adapter.
// - Holds one miss and one writeback, serialises them as line bursts, and packs read beats into a full line.
// PARAMETERS
// PLEN        32   physical address width
// LINE_WIDTH  256  dcache line width in bits (Cfg.DCACHE_LINE_WIDTH)
// WAY_WIDTH   2    way index width (Cfg.DCACHE_SET_ASSOC_WIDTH)
// BUS_WIDTH   64   memory data beat width; NBEAT=LINE_WIDTH/BUS_WIDTH must be a power of 2 and >=2
// PORTS
// clk_i          in   1      clock
// rst_ni         in   1      synchronous active-low reset
// miss_req_valid_i/ready_o  in/out 1  miss handshake
// miss_req_paddr_i     in   PLEN        miss address
// miss_req_victim_way_i in  WAY_WIDTH   way to refill
// wb_req_valid_i/ready_o    in/out 1    writeback handshake
// wb_req_paddr_i       in   PLEN        victim line address
// wb_req_data_i        in   LINE_WIDTH  victim line data
// refill_valid_o/ready_i    out/in 1    refill handshake to dcache
// refill_paddr_o       out  PLEN        line-aligned refill address
// refill_way_o         out  WAY_WIDTH   way from the latched miss
// refill_data_o        out  LINE_WIDTH  assembled line
// mem_req_valid_o/ready_i   out/in 1    burst address handshake
// mem_req_we_o         out  1           1=write burst, 0=read burst
// mem_req_addr_o       out  PLEN        line-aligned burst address
// mem_wdata_valid_o/ready_i out/in 1    write beat handshake
// mem_wdata_o          out  BUS_WIDTH   write beat; beat 0 = line bits [BUS_WIDTH-1:0]
// mem_wdata_last_o     out  1           final write beat
// mem_rsp_valid_i      in   1           read beat, or write ack (single pulse)
// mem_rsp_data_i       in   BUS_WIDTH   read beat data, in ascending order
// busy_o               out  1           FSM not IDLE, or any buffer valid
// BEHAVIOUR
// - Reset (rst_ni=0 at a posedge): FSM=IDLE; both buffers, beat counter and refill_valid_o cleared.
//   - All valid outputs and busy_o are 0; the burst in flight is abandoned.
// - Buffers:
//   - miss_req_ready_o = !miss_buf_v. On handshake, latch paddr with the low log2(LINE_WIDTH/8) bits zeroed, plus the way.
//   - wb_req_ready_o = !wb_buf_v; same alignment rule applies.
//   - Each buffer clears the cycle its transaction completes. A new handshake may be accepted that same cycle only from the next cycle on (ready is registered off the valid bit).
// - Arbitration in IDLE: writeback has strict priority over miss; this keeps dirty data ahead of any re-read of the same line.
// - FSM states:
//   - IDLE -> WB_ADDR if wb_buf_v; else RD_ADDR if miss_buf_v.
//   - WB_ADDR: mem_req_valid_o=1, we=1. Handshake -> WB_DATA, beat=0.
//   - WB_DATA: mem_wdata_valid_o=1, data = line slice [beat]. Each handshake beat++.
//     - last = (beat==NBEAT-1); a last handshake -> WB_ACK.
//   - WB_ACK: wait for mem_rsp_valid_i -> clear wb_buf_v -> IDLE.
//   - RD_ADDR: mem_req_valid_o=1, we=0. Handshake -> RD_DATA, beat=0.
//   - RD_DATA: each mem_rsp_valid_i writes the beat into line slice [beat], beat++.
//     - mem_rsp_last_i, or beat==NBEAT-1 -> REFILL.
//     - mem_rsp_last_i early (beat<NBEAT-1) is a protocol error: still go to REFILL; unwritten slices are 0.
//   - REFILL: refill_valid_o=1; paddr/way/data held stable until refill_ready_i. Handshake -> clear miss_buf_v -> IDLE.
// - mem_req_valid_o and mem_wdata_valid_o, once asserted, stay high with stable payload until ready.
// - mem_rsp_valid_i outside WB_ACK/RD_DATA is ignored.
// - Minimum latency: miss handshake to refill_valid_o = 2 + NBEAT cycles with ready memory and no pending writeback.
// - Back-to-back: IDLE always spends one cycle; the next burst starts the cycle after IDLE.
// TESTING
// 1. Miss paddr=0x8000_0024, way=2; mem beats D0..D3 (D3 last) -> mem_req_addr_o=0x8000_0020, we=0; refill_data_o={D3,D2,D1,D0}, refill_way_o=2.
// 2. Miss and wb (paddr=0x8000_0020, data=L) valid same cycle -> write burst first: 4 beats L[63:0]..L[255:192], last on beat 3; read burst issued only after the ack.
// 3. Second miss while first is in RD_DATA -> miss_req_ready_o=0 until first refill handshake +1 cycle; second miss then served normally.
// 4. refill_ready_i held 0 for 5 cycles -> refill_valid_o/data stable for 5 cycles; no new mem_req_valid_o issued.
// 5. mem_wdata_ready_i toggling 1,0,0,1 -> same beat held while stalled; exactly 4 beats transferred, one last.
// 6. rst_ni low mid-RD_DATA -> next cycle all valids/busy_o=0; a fresh miss completes correctly.

Source files
------------

// File: rtl/dcache_mem_sched_if.sv
// Bundle of the dcache-side and memory-side handshakes of the dcache memory
// scheduler. The slave modport is the scheduler's view; master is the
// environment's (dcache + memory adapter) view.
interface dcache_mem_sched_if #(
    parameter int PLEN       = 32,
    parameter int LINE_WIDTH = 256,
    parameter int WAY_WIDTH  = 2,
    parameter int BUS_WIDTH  = 64
);
    // dcache miss request
    logic                  miss_req_valid_i;
    logic                  miss_req_ready_o;
    logic [PLEN-1:0]       miss_req_paddr_i;
    logic [WAY_WIDTH-1:0]  miss_req_victim_way_i;
    // dcache writeback request
    logic                  wb_req_valid_i;
    logic                  wb_req_ready_o;
    logic [PLEN-1:0]       wb_req_paddr_i;
    logic [LINE_WIDTH-1:0] wb_req_data_i;
    // refill towards the dcache
    logic                  refill_valid_o;
    logic                  refill_ready_i;
    logic [PLEN-1:0]       refill_paddr_o;
    logic [WAY_WIDTH-1:0]  refill_way_o;
    logic [LINE_WIDTH-1:0] refill_data_o;
    // burst address channel
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic                  mem_req_we_o;
    logic [PLEN-1:0]       mem_req_addr_o;
    // write beat channel
    logic                  mem_wdata_valid_o;
    logic                  mem_wdata_ready_i;
    logic [BUS_WIDTH-1:0]  mem_wdata_o;
    logic                  mem_wdata_last_o;
    // read beats / write ack
    logic                  mem_rsp_valid_i;
    logic [BUS_WIDTH-1:0]  mem_rsp_data_i;
    logic                  mem_rsp_last_i;
    // status
    logic                  busy_o;

    modport slave (
        input  miss_req_valid_i, miss_req_paddr_i, miss_req_victim_way_i,
        output miss_req_ready_o,
        input  wb_req_valid_i, wb_req_paddr_i, wb_req_data_i,
        output wb_req_ready_o,
        output refill_valid_o, refill_paddr_o, refill_way_o, refill_data_o,
        input  refill_ready_i,
        output mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
        input  mem_req_ready_i,
        output mem_wdata_valid_o, mem_wdata_o, mem_wdata_last_o,
        input  mem_wdata_ready_i,
        input  mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_last_i,
        output busy_o
    );

    modport master (
        output miss_req_valid_i, miss_req_paddr_i, miss_req_victim_way_i,
        input  miss_req_ready_o,
        output wb_req_valid_i, wb_req_paddr_i, wb_req_data_i,
        input  wb_req_ready_o,
        input  refill_valid_o, refill_paddr_o, refill_way_o, refill_data_o,
        output refill_ready_i,
        input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
        output mem_req_ready_i,
        input  mem_wdata_valid_o, mem_wdata_o, mem_wdata_last_o,
        output mem_wdata_ready_i,
        output mem_rsp_valid_i, mem_rsp_data_i, mem_rsp_last_i,
        input  busy_o
    );
endinterface

// File: rtl/dcache_mem_sched.sv
// dcache memory scheduler: holds one miss and one dirty-line writeback and
// serialises them as line bursts on a single memory port. Writebacks win
// arbitration so dirty data always reaches memory before a re-read of the
// same line. Read beats are packed into a full line and returned as a refill.
module dcache_mem_sched #(
    parameter int PLEN       = 32,
    parameter int LINE_WIDTH = 256,
    parameter int WAY_WIDTH  = 2,
    parameter int BUS_WIDTH  = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    dcache_mem_sched_if.slave  bus
);
    localparam int NBEAT  = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_W = $clog2(NBEAT);
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);
    localparam logic [PLEN-1:0]   OFF_MASK  = PLEN'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_ADDR = 3'd1,
        S_WB_DATA = 3'd2,
        S_WB_ACK  = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_REFILL  = 3'd6
    } state_e;

    state_e                              state_r;
    state_e                              state_s;
    logic                                miss_buf_v_r;
    logic [PLEN-1:0]                     miss_paddr_r;
    logic [WAY_WIDTH-1:0]                miss_way_r;
    logic                                wb_buf_v_r;
    logic [PLEN-1:0]                     wb_paddr_r;
    logic [NBEAT-1:0][BUS_WIDTH-1:0]     wb_data_r;
    logic [BEAT_W-1:0]                   beat_r;
    logic [NBEAT-1:0][BUS_WIDTH-1:0]     line_r;

    logic miss_acc_s;
    logic wb_acc_s;
    logic miss_done_s;
    logic wb_done_s;
    logic beat_clr_s;
    logic beat_inc_s;
    logic line_clr_s;
    logic line_wr_s;

    // Strip the byte offset so every burst and refill is line aligned.
    function automatic logic [PLEN-1:0] line_align(input logic [PLEN-1:0] a);
        return a & ~OFF_MASK;
    endfunction

    assign miss_acc_s = bus.miss_req_valid_i & ~miss_buf_v_r;
    assign wb_acc_s   = bus.wb_req_valid_i & ~wb_buf_v_r;

    // Outputs decode directly from registered state/buffers, so they are
    // stable for as long as the FSM waits on the corresponding ready.
    assign bus.miss_req_ready_o  = ~miss_buf_v_r;
    assign bus.wb_req_ready_o    = ~wb_buf_v_r;
    assign bus.mem_req_valid_o   = (state_r == S_WB_ADDR) || (state_r == S_RD_ADDR);
    assign bus.mem_req_we_o      = (state_r == S_WB_ADDR);
    assign bus.mem_req_addr_o    = (state_r == S_WB_ADDR) ? wb_paddr_r : miss_paddr_r;
    assign bus.mem_wdata_valid_o = (state_r == S_WB_DATA);
    assign bus.mem_wdata_o       = wb_data_r[beat_r];
    assign bus.mem_wdata_last_o  = (state_r == S_WB_DATA) && (beat_r == LAST_BEAT);
    assign bus.refill_valid_o    = (state_r == S_REFILL);
    assign bus.refill_paddr_o    = miss_paddr_r;
    assign bus.refill_way_o      = miss_way_r;
    assign bus.refill_data_o     = line_r;
    assign bus.busy_o            = (state_r != S_IDLE) || miss_buf_v_r || wb_buf_v_r;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath strobes; IDLE always costs one cycle between bursts.
    always_comb begin
        state_s     = state_r;
        miss_done_s = 1'b0;
        wb_done_s   = 1'b0;
        beat_clr_s  = 1'b0;
        beat_inc_s  = 1'b0;
        line_clr_s  = 1'b0;
        line_wr_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (wb_buf_v_r) begin
                    state_s = S_WB_ADDR;
                end else if (miss_buf_v_r) begin
                    state_s = S_RD_ADDR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WB_ADDR: begin
                if (bus.mem_req_ready_i) begin
                    state_s    = S_WB_DATA;
                    beat_clr_s = 1'b1;
                end else begin
                    state_s = S_WB_ADDR;
                end
            end
            S_WB_DATA: begin
                if (bus.mem_wdata_ready_i) begin
                    beat_inc_s = 1'b1;
                    if (beat_r == LAST_BEAT) begin
                        state_s = S_WB_ACK;
                    end else begin
                        state_s = S_WB_DATA;
                    end
                end else begin
                    state_s = S_WB_DATA;
                end
            end
            S_WB_ACK: begin
                if (bus.mem_rsp_valid_i) begin
                    wb_done_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    state_s = S_WB_ACK;
                end
            end
            S_RD_ADDR: begin
                if (bus.mem_req_ready_i) begin
                    state_s    = S_RD_DATA;
                    beat_clr_s = 1'b1;
                    line_clr_s = 1'b1;
                end else begin
                    state_s = S_RD_ADDR;
                end
            end
            S_RD_DATA: begin
                if (bus.mem_rsp_valid_i) begin
                    line_wr_s  = 1'b1;
                    beat_inc_s = 1'b1;
                    // An early last is a protocol error; the unwritten slices stay zero.
                    if (bus.mem_rsp_last_i || (beat_r == LAST_BEAT)) begin
                        state_s = S_REFILL;
                    end else begin
                        state_s = S_RD_DATA;
                    end
                end else begin
                    state_s = S_RD_DATA;
                end
            end
            S_REFILL: begin
                if (bus.refill_ready_i) begin
                    miss_done_s = 1'b1;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_REFILL;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Request buffers, beat counter and refill line assembly.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            miss_buf_v_r <= 1'b0;
            miss_paddr_r <= '0;
            miss_way_r   <= '0;
            wb_buf_v_r   <= 1'b0;
            wb_paddr_r   <= '0;
            wb_data_r    <= '0;
            beat_r       <= '0;
            line_r       <= '0;
        end else begin
            if (miss_acc_s) begin
                miss_buf_v_r <= 1'b1;
                miss_paddr_r <= line_align(bus.miss_req_paddr_i);
                miss_way_r   <= bus.miss_req_victim_way_i;
            end else if (miss_done_s) begin
                miss_buf_v_r <= 1'b0;
            end
            if (wb_acc_s) begin
                wb_buf_v_r <= 1'b1;
                wb_paddr_r <= line_align(bus.wb_req_paddr_i);
                wb_data_r  <= bus.wb_req_data_i;
            end else if (wb_done_s) begin
                wb_buf_v_r <= 1'b0;
            end
            if (beat_clr_s) begin
                beat_r <= '0;
            end else if (beat_inc_s) begin
                beat_r <= beat_r + BEAT_W'(1);
            end
            if (line_clr_s) begin
                line_r <= '0;
            end else if (line_wr_s) begin
                line_r[beat_r] <= bus.mem_rsp_data_i;
            end
        end
    end
endmodule

// File: tb/tb_dcache_mem_sched.sv
// Bench for dcache_mem_sched: a memory/dcache responder with logging,
// a table of single-miss vectors, directed corner sequences and a random
// phase scored against transaction-level expectations.
module tb_dcache_mem_sched;
    localparam int PLEN = 32;
    localparam int LW   = 256;
    localparam int WW   = 2;
    localparam int BW   = 64;
    localparam int NB   = LW / BW;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    dcache_mem_sched_if #(.PLEN(PLEN), .LINE_WIDTH(LW), .WAY_WIDTH(WW), .BUS_WIDTH(BW)) bus ();

    dcache_mem_sched #(.PLEN(PLEN), .LINE_WIDTH(LW), .WAY_WIDTH(WW), .BUS_WIDTH(BW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder modes
    int req_rdy_mode = 0;   // 0 always ready, 1 random
    int wr_rdy_mode  = 0;   // 0 always, 1 random, 2 pattern 1,0,0,1
    int rsp_mode     = 0;   // 0 every cycle, 1 random gaps, 2 every third cycle, 3 never
    int rfl_mode     = 0;   // 0 always, 1 random, 2 hold low

    typedef struct { logic we; logic [31:0] addr; int at; } req_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [1:0] way; logic [255:0] data; int at; } rfl_t;
    req_t  req_log[$];
    beat_t wbeat_log[$];
    rfl_t  rfl_log[$];
    int    ack_cnt = 0;
    int    ack_at  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a, input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return {a, 16'hBEEF, kk};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < NB; k++) l[k*64 +: 64] = mem_word(a, k);
        return l;
    endfunction

    function automatic logic [63:0] slice(input logic [255:0] l, input int k);
        return l[k*64 +: 64];
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    // Memory and dcache responder: acts at every falling edge, handshakes
    // complete at the following rising edge.
    initial begin
        logic [31:0] rd_q[$];
        int   rd_beat, ack_cd, wpat_k, slow_k;
        logic go, rdy;
        logic p_req_st, p_wd_st, p_rf_st;
        logic [32:0]  p_req;
        logic [64:0]  p_wd;
        logic [289:0] p_rf;
        logic [3:0]   pat;
        pat = 4'b1001;
        rd_beat = 0; ack_cd = 0; wpat_k = 0; slow_k = 0;
        p_req_st = 1'b0; p_wd_st = 1'b0; p_rf_st = 1'b0;
        p_req = '0; p_wd = '0; p_rf = '0;
        bus.mem_req_ready_i = 1'b0; bus.mem_wdata_ready_i = 1'b0; bus.refill_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_data_i = '0; bus.mem_rsp_last_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                rd_q.delete(); rd_beat = 0; ack_cd = 0;
                p_req_st = 1'b0; p_wd_st = 1'b0; p_rf_st = 1'b0;
                bus.mem_req_ready_i = 1'b0; bus.mem_wdata_ready_i = 1'b0; bus.refill_ready_i = 1'b0;
                bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_last_i = 1'b0;
                continue;
            end
            // payload must hold while a valid is stalled
            if (p_req_st) chk("req_hold", {bus.mem_req_valid_o, bus.mem_req_we_o, bus.mem_req_addr_o}, {1'b1, p_req});
            if (p_wd_st)  chk("wdata_hold", {bus.mem_wdata_valid_o, bus.mem_wdata_last_o, bus.mem_wdata_o}, {1'b1, p_wd});
            if (p_rf_st)  chk("refill_hold", {bus.refill_valid_o, bus.refill_way_o, bus.refill_paddr_o, bus.refill_data_o}, {1'b1, p_rf});
            // read beats, then write ack
            bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_last_i = 1'b0; bus.mem_rsp_data_i = '0;
            if (rd_q.size() > 0) begin
                case (rsp_mode)
                    0: go = 1'b1;
                    1: go = ($urandom_range(0, 2) != 0);
                    2: begin go = ((slow_k % 3) == 2); slow_k++; end
                    default: go = 1'b0;
                endcase
                if (go) begin
                    bus.mem_rsp_valid_i = 1'b1;
                    bus.mem_rsp_data_i  = mem_word(rd_q[0], rd_beat);
                    bus.mem_rsp_last_i  = (rd_beat == NB - 1);
                    rd_beat++;
                    if (rd_beat == NB) begin
                        void'(rd_q.pop_front());
                        rd_beat = 0;
                    end
                end
            end else if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) begin
                    bus.mem_rsp_valid_i = 1'b1;
                    ack_at = cyc + 1;
                    ack_cnt++;
                end
            end
            // burst address channel
            rdy = (req_rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.mem_req_ready_i = rdy;
            p_req_st = bus.mem_req_valid_o && !rdy;
            p_req    = {bus.mem_req_we_o, bus.mem_req_addr_o};
            if (bus.mem_req_valid_o && rdy) begin
                req_log.push_back('{bus.mem_req_we_o, bus.mem_req_addr_o, cyc + 1});
                if (!bus.mem_req_we_o) rd_q.push_back(bus.mem_req_addr_o);
            end
            // write beat channel
            case (wr_rdy_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = pat[wpat_k % 4];
                    if (bus.mem_wdata_valid_o) wpat_k++;
                end
            endcase
            bus.mem_wdata_ready_i = rdy;
            p_wd_st = bus.mem_wdata_valid_o && !rdy;
            p_wd    = {bus.mem_wdata_last_o, bus.mem_wdata_o};
            if (bus.mem_wdata_valid_o && rdy) begin
                wbeat_log.push_back('{bus.mem_wdata_o, bus.mem_wdata_last_o});
                if (bus.mem_wdata_last_o) ack_cd = 1 + $urandom_range(0, 2);
            end
            if (wr_rdy_mode != 2) wpat_k = 0;
            // refill channel
            case (rfl_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b0;
            endcase
            bus.refill_ready_i = rdy;
            p_rf_st = bus.refill_valid_o && !rdy;
            p_rf    = {bus.refill_way_o, bus.refill_paddr_o, bus.refill_data_o};
            if (bus.refill_valid_o && rdy)
                rfl_log.push_back('{bus.refill_paddr_o, bus.refill_way_o, bus.refill_data_o, cyc + 1});
        end
    end

    task automatic send_miss(input logic [31:0] a, input logic [1:0] w, output int hs);
        int n;
        n = 0;
        @(negedge clk);
        bus.miss_req_valid_i = 1'b1; bus.miss_req_paddr_i = a; bus.miss_req_victim_way_i = w;
        while (!bus.miss_req_ready_o && n < 400) begin @(negedge clk); n++; end
        hs = cyc + 1;
        if (n >= 400) begin chk("miss_accept_timeout", 1'b0, 1'b1); hs = -1; end
        @(negedge clk);
        bus.miss_req_valid_i = 1'b0;
    endtask

    task automatic send_wb(input logic [31:0] a, input logic [255:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.wb_req_valid_i = 1'b1; bus.wb_req_paddr_i = a; bus.wb_req_data_i = d;
        while (!bus.wb_req_ready_o && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) chk("wb_accept_timeout", 1'b0, 1'b1);
        @(negedge clk);
        bus.wb_req_valid_i = 1'b0;
    endtask

    task automatic wait_rfl(input int n);
        int t;
        t = 0;
        while (rfl_log.size() < n && t < 3000) begin @(negedge clk); t++; end
        chk("refill_count", rfl_log.size(), n);
    endtask

    task automatic wait_acks(input int n);
        int t;
        t = 0;
        while (ack_cnt < n && t < 3000) begin @(negedge clk); t++; end
        chk("ack_count", ack_cnt, n);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy_o && t < 3000) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("idle", bus.busy_o, 1'b0);
    endtask

    task automatic clear_logs();
        req_log.delete(); wbeat_log.delete(); rfl_log.delete();
    endtask

    typedef struct { logic [31:0] paddr; logic [1:0] way; logic [31:0] exp_addr; } vec_t;

    initial begin
        vec_t vt[6];
        logic [255:0] l;
        logic [31:0]  a;
        int hs, hs2, base, ri, wi, lastc, t;
        logic [31:0]  mexp_a[$];
        logic [1:0]   mexp_w[$];
        logic [31:0]  wexp_a[$];
        logic [255:0] wexp_d[$];

        vt[0] = '{32'h8000_0024, 2'd2, 32'h8000_0020};
        vt[1] = '{32'h1234_567F, 2'd1, 32'h1234_5660};
        vt[2] = '{32'hFFFF_FFFF, 2'd3, 32'hFFFF_FFE0};
        vt[3] = '{32'h0000_001F, 2'd0, 32'h0000_0000};
        vt[4] = '{32'h0000_0020, 2'd3, 32'h0000_0020};
        vt[5] = '{32'hA5A5_5A41, 2'd1, 32'hA5A5_5A40};

        bus.miss_req_valid_i = 1'b0; bus.miss_req_paddr_i = '0; bus.miss_req_victim_way_i = '0;
        bus.wb_req_valid_i = 1'b0; bus.wb_req_paddr_i = '0; bus.wb_req_data_i = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_req_valid", bus.mem_req_valid_o, 1'b0);
        chk("rst_wdata_valid", bus.mem_wdata_valid_o, 1'b0);
        chk("rst_refill_valid", bus.refill_valid_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_readies", {bus.miss_req_ready_o, bus.wb_req_ready_o}, 2'b11);
        rst_ni = 1'b1;

        // single-miss vectors with an always-ready memory
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            send_miss(vt[i].paddr, vt[i].way, hs);
            wait_rfl(1);
            chk("vec_req_count", req_log.size(), 1);
            if (req_log.size() > 0) chk("vec_req_we_addr", {req_log[0].we, req_log[0].addr}, {1'b0, vt[i].exp_addr});
            if (rfl_log.size() > 0) begin
                chk("vec_refill_addr", rfl_log[0].addr, vt[i].exp_addr);
                chk("vec_refill_way", rfl_log[0].way, vt[i].way);
                chk("vec_refill_data", rfl_log[0].data, line_of(vt[i].exp_addr));
                // refill_valid rises 2+NB cycles after the miss handshake
                chk("vec_latency", rfl_log[0].at - hs, 3 + NB);
            end
            wait_idle();
        end

        // writeback and miss offered together: write burst goes first
        clear_logs();
        l = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        base = ack_cnt;
        fork
            send_wb(32'h8000_0020, l);
            send_miss(32'h8000_0024, 2'd2, hs);
        join
        wait_rfl(1);
        wait_idle();
        chk("prio_req_count", req_log.size(), 2);
        if (req_log.size() >= 2) begin
            chk("prio_first_write", {req_log[0].we, req_log[0].addr}, {1'b1, 32'h8000_0020});
            chk("prio_then_read", {req_log[1].we, req_log[1].addr}, {1'b0, 32'h8000_0020});
            chk("prio_read_after_ack", (req_log[1].at > ack_at), 1'b1);
        end
        chk("prio_ack_count", ack_cnt - base, 1);
        chk("prio_beat_count", wbeat_log.size(), NB);
        for (int k = 0; k < wbeat_log.size(); k++)
            chk("prio_beat", {wbeat_log[k].last, wbeat_log[k].data}, {(k == NB - 1), slice(l, k)});
        if (rfl_log.size() > 0) chk("prio_refill_data", rfl_log[0].data, line_of(32'h8000_0020));

        // second miss held off until the first refill completes
        clear_logs();
        rsp_mode = 2;
        send_miss(32'h4000_1000, 2'd1, hs);
        send_miss(32'h4000_2008, 2'd3, hs2);
        wait_rfl(2);
        rsp_mode = 0;
        if (rfl_log.size() >= 2) begin
            chk("miss2_accept_edge", hs2, rfl_log[0].at + 1);
            chk("miss2_refill", {rfl_log[1].way, rfl_log[1].addr}, {2'd3, 32'h4000_2000});
            chk("miss2_data", rfl_log[1].data, line_of(32'h4000_2000));
        end
        wait_idle();

        // refill stalled for five cycles while a writeback waits
        clear_logs();
        rfl_mode = 2;
        base = ack_cnt;
        send_miss(32'h0C00_0040, 2'd0, hs);
        t = 0;
        while (!bus.refill_valid_o && t < 200) begin @(negedge clk); t++; end
        chk("stall_refill_seen", bus.refill_valid_o, 1'b1);
        l = {8{$urandom()}};
        bus.wb_req_valid_i = 1'b1; bus.wb_req_paddr_i = 32'h0C00_0400; bus.wb_req_data_i = l;
        for (int k = 0; k < 5; k++) begin
            chk("stall_refill_valid", bus.refill_valid_o, 1'b1);
            chk("stall_refill_data", bus.refill_data_o, line_of(32'h0C00_0040));
            chk("stall_no_mem_req", bus.mem_req_valid_o, 1'b0);
            @(negedge clk);
            bus.wb_req_valid_i = 1'b0;
        end
        rfl_mode = 0;
        wait_rfl(1);
        wait_acks(base + 1);
        wait_idle();
        chk("stall_req_count", req_log.size(), 2);
        if (req_log.size() >= 2) chk("stall_wb_req", {req_log[1].we, req_log[1].addr}, {1'b1, 32'h0C00_0400});

        // write beats under a 1,0,0,1 ready pattern
        clear_logs();
        wr_rdy_mode = 2;
        base = ack_cnt;
        l = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        send_wb(32'h2222_3333, l);
        wait_acks(base + 1);
        wait_idle();
        wr_rdy_mode = 0;
        chk("wpat_beat_count", wbeat_log.size(), NB);
        lastc = 0;
        for (int k = 0; k < wbeat_log.size(); k++) begin
            chk("wpat_beat", {wbeat_log[k].last, wbeat_log[k].data}, {(k == NB - 1), slice(l, k)});
            lastc += int'(wbeat_log[k].last);
        end
        chk("wpat_last_count", lastc, 1);
        if (req_log.size() > 0) chk("wpat_addr", req_log[0].addr, 32'h2222_3320);

        // reset in the middle of a read burst
        clear_logs();
        rsp_mode = 3;
        send_miss(32'h5555_0000, 2'd2, hs);
        t = 0;
        while (req_log.size() == 0 && t < 200) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mid_rst_valids", {bus.mem_req_valid_o, bus.mem_wdata_valid_o, bus.refill_valid_o}, 3'b000);
        chk("mid_rst_busy", bus.busy_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        rsp_mode = 0;
        clear_logs();
        send_miss(32'h6666_0010, 2'd1, hs);
        wait_rfl(1);
        if (rfl_log.size() > 0)
            chk("post_rst_refill", {rfl_log[0].way, rfl_log[0].addr, rfl_log[0].data},
                {2'd1, 32'h6666_0000, line_of(32'h6666_0000)});
        wait_idle();

        // random traffic with random stalls on every channel
        clear_logs();
        req_rdy_mode = 1; wr_rdy_mode = 1; rsp_mode = 1; rfl_mode = 1;
        base = ack_cnt;
        fork
            begin
                int h;
                logic [31:0] ra;
                logic [1:0]  rw;
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    ra = $urandom(); rw = 2'($urandom_range(0, 3));
                    send_miss(ra, rw, h);
                    mexp_a.push_back(align(ra)); mexp_w.push_back(rw);
                end
            end
            begin
                logic [31:0]  wa;
                logic [255:0] wd;
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 10)) @(negedge clk);
                    wa = $urandom();
                    wd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                    send_wb(wa, wd);
                    wexp_a.push_back(align(wa)); wexp_d.push_back(wd);
                end
            end
        join
        wait_rfl(20);
        wait_acks(base + 12);
        wait_idle();
        ri = 0; wi = 0;
        foreach (req_log[i]) begin
            if (req_log[i].we) begin
                if (wi < wexp_a.size()) chk("rnd_wr_addr", req_log[i].addr, wexp_a[wi]);
                wi++;
            end else begin
                if (ri < mexp_a.size()) chk("rnd_rd_addr", req_log[i].addr, mexp_a[ri]);
                ri++;
            end
        end
        chk("rnd_rd_bursts", ri, 20);
        chk("rnd_wr_bursts", wi, 12);
        chk("rnd_beats", wbeat_log.size(), 12 * NB);
        foreach (wbeat_log[i])
            if (i / NB < wexp_d.size())
                chk("rnd_beat", {wbeat_log[i].last, wbeat_log[i].data},
                    {((i % NB) == NB - 1), slice(wexp_d[i / NB], i % NB)});
        foreach (rfl_log[i])
            if (i < mexp_a.size())
                chk("rnd_refill", {rfl_log[i].way, rfl_log[i].addr, rfl_log[i].data},
                    {mexp_w[i], mexp_a[i], line_of(mexp_a[i])});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
